csr_trap_unit: RTL and testbench

Machine-mode CSR file with trap sequencing, interrupt arbitration and retirement counters; successor to the single-hart fixed-layout CSR block. It sits beside the commit stage. It owns privilege mode, performs trap entry and mret, and requests interrupts through a handshake with the pipeline. It drives redirect targets to fetch. Widths, interrupt-line count and counter width are parametrised, and vectored mtvec is added.

---
 rtl/csr_trap_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_unit
// Machine-mode CSR file with trap entry / mret sequencing, interrupt
// arbitration and cycle / retirement counters.
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_unit #(
  parameter int              XLEN    = 64,
  parameter int              NUM_IRQ = 12,
  parameter int              CNT_W   = 64,
  parameter logic [XLEN-1:0] HARTID  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit_valid,
  input  logic               csr_we,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  input  logic               exc_valid,
  input  logic [5:0]         exc_code,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic               mret,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_req,
  input  logic               irq_accept,
  input  logic [XLEN-1:0]    irq_epc,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [1:0]         priv,
  output logic [XLEN-1:0]    satp
);

  localparam logic [11:0] c_A_MSTATUS  = 12'h300;
  localparam logic [11:0] c_A_MIE      = 12'h304;
  localparam logic [11:0] c_A_MTVEC    = 12'h305;
  localparam logic [11:0] c_A_MSCRATCH = 12'h340;
  localparam logic [11:0] c_A_MEPC     = 12'h341;
  localparam logic [11:0] c_A_MCAUSE   = 12'h342;
  localparam logic [11:0] c_A_MTVAL    = 12'h343;
  localparam logic [11:0] c_A_MIP      = 12'h344;
  localparam logic [11:0] c_A_MCYCLE   = 12'hB00;
  localparam logic [11:0] c_A_MINSTRET = 12'hB02;
  localparam logic [11:0] c_A_MHARTID  = 12'hF14;
  localparam logic [11:0] c_A_SATP     = 12'h180;

  localparam logic [1:0] c_OP_NONE  = 2'b00;
  localparam logic [1:0] c_OP_WRITE = 2'b01;
  localparam logic [1:0] c_OP_SET   = 2'b10;
  localparam logic [1:0] c_OP_CLEAR = 2'b11;
  localparam logic [1:0] c_PRIV_M   = 2'b11;

  logic [1:0]         r_priv;
  logic               r_st_mie;
  logic               r_st_mpie;
  logic [1:0]         r_st_mpp;
  logic [NUM_IRQ-1:0] r_mie;
  logic [NUM_IRQ-1:0] r_mip;
  logic [XLEN-1:0]    r_mtvec;
  logic [XLEN-1:0]    r_mscratch;
  logic [XLEN-1:0]    r_mepc;
  logic [XLEN-1:0]    r_mcause;
  logic [XLEN-1:0]    r_mtval;
  logic [XLEN-1:0]    r_satp;
  logic [CNT_W-1:0]   r_mcycle;
  logic [CNT_W-1:0]   r_minstret;
  logic               r_redirect_valid;
  logic [XLEN-1:0]    r_redirect_pc;

  logic [XLEN-1:0]    w_mstatus;
  logic [XLEN-1:0]    w_rdata;
  logic [XLEN-1:0]    w_wval;
  logic [XLEN-1:0]    w_tvec_base;
  logic [XLEN-1:0]    w_trap_pc;
  logic [XLEN-1:0]    w_irq_cause;
  logic               w_impl;
  logic               w_illegal;
  logic [NUM_IRQ-1:0] w_pending;
  logic [3:0]         w_irq_idx;
  logic               w_irq_req;
  logic               w_take_irq;
  logic               w_take_exc;
  logic               w_take_mret;
  logic               w_do_write;
  logic               w_retire;

  always_comb begin
    w_mstatus          = '0;
    w_mstatus[3]       = r_st_mie;
    w_mstatus[7]       = r_st_mpie;
    w_mstatus[12:11]   = r_st_mpp;
  end

  always_comb begin
    w_impl  = 1'b1;
    w_rdata = '0;
    case (csr_addr)
      c_A_MSTATUS:  w_rdata = w_mstatus;
      c_A_MIE:      w_rdata = XLEN'(r_mie);
      c_A_MTVEC:    w_rdata = r_mtvec;
      c_A_MSCRATCH: w_rdata = r_mscratch;
      c_A_MEPC:     w_rdata = r_mepc;
      c_A_MCAUSE:   w_rdata = r_mcause;
      c_A_MTVAL:    w_rdata = r_mtval;
      c_A_MIP:      w_rdata = XLEN'(r_mip);
      c_A_MCYCLE:   w_rdata = XLEN'(r_mcycle);
      c_A_MINSTRET: w_rdata = XLEN'(r_minstret);
      c_A_MHARTID:  w_rdata = HARTID;
      c_A_SATP:     w_rdata = r_satp;
      default:      w_impl  = 1'b0;
    endcase
  end

  assign w_illegal = ~w_impl | (r_priv < csr_addr[9:8]) |
                     ((csr_op != c_OP_NONE) & (csr_addr[11:10] == 2'b11));

  always_comb begin
    case (csr_op)
      c_OP_WRITE: w_wval = csr_wdata;
      c_OP_SET:   w_wval = w_rdata | csr_wdata;
      c_OP_CLEAR: w_wval = w_rdata & ~csr_wdata;
      default:    w_wval = w_rdata;
    endcase
  end

  // Highest pending index wins: later iterations overwrite earlier ones.
  assign w_pending = r_mip & r_mie;
  always_comb begin
    w_irq_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_pending[i]) w_irq_idx = 4'(i);
    end
  end

  always_comb begin
    w_irq_cause            = '0;
    w_irq_cause[XLEN-1]    = 1'b1;
    w_irq_cause[3:0]       = w_irq_idx;
  end

  assign w_irq_req   = (|w_pending) & ((r_priv != c_PRIV_M) | r_st_mie) & ~r_redirect_valid;
  assign w_take_irq  = irq_accept & w_irq_req;
  assign w_take_exc  = ~w_take_irq & commit_valid & exc_valid;
  assign w_take_mret = ~w_take_irq & ~w_take_exc & commit_valid & mret;
  assign w_do_write  = ~w_take_irq & ~w_take_exc & ~w_take_mret & commit_valid &
                       csr_we & (csr_op != c_OP_NONE) & ~w_illegal;
  assign w_retire    = ~w_take_irq & commit_valid & ~exc_valid;

  assign w_tvec_base = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_trap_pc   = (w_take_irq && r_mtvec[0]) ?
                       w_tvec_base + XLEN'({w_irq_idx, 2'b00}) : w_tvec_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_priv           <= c_PRIV_M;
      r_st_mie         <= 1'b0;
      r_st_mpie        <= 1'b0;
      r_st_mpp         <= 2'b00;
      r_mie            <= '0;
      r_mip            <= '0;
      r_mtvec          <= '0;
      r_mscratch       <= '0;
      r_mepc           <= '0;
      r_mcause         <= '0;
      r_mtval          <= '0;
      r_satp           <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_mip            <= irq_in;
      r_redirect_valid <= 1'b0;
      if (w_take_irq || w_take_exc) begin
        r_st_mpie        <= r_st_mie;
        r_st_mie         <= 1'b0;
        r_st_mpp         <= r_priv;
        r_priv           <= c_PRIV_M;
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= w_trap_pc;
        if (w_take_irq) begin
          r_mepc   <= {irq_epc[XLEN-1:2], 2'b00};
          r_mtval  <= '0;
          r_mcause <= w_irq_cause;
        end else begin
          r_mepc   <= {exc_pc[XLEN-1:2], 2'b00};
          r_mtval  <= exc_tval;
          r_mcause <= XLEN'(exc_code);
        end
      end else if (w_take_mret) begin
        r_priv           <= r_st_mpp;
        r_st_mie         <= r_st_mpie;
        r_st_mpie        <= 1'b1;
        r_st_mpp         <= 2'b00;
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= r_mepc;
      end else if (w_do_write) begin
        case (csr_addr)
          c_A_MSTATUS: begin
            r_st_mie  <= w_wval[3];
            r_st_mpie <= w_wval[7];
            r_st_mpp  <= w_wval[12:11];
          end
          c_A_MIE:      r_mie      <= w_wval[NUM_IRQ-1:0];
          c_A_MTVEC:    r_mtvec    <= {w_wval[XLEN-1:2], 1'b0, w_wval[0]};
          c_A_MSCRATCH: r_mscratch <= w_wval;
          c_A_MEPC:     r_mepc     <= {w_wval[XLEN-1:2], 2'b00};
          c_A_MCAUSE:   r_mcause   <= w_wval;
          c_A_MTVAL:    r_mtval    <= w_wval;
          c_A_SATP:     r_satp     <= w_wval;
          default: ;
        endcase
      end
    end
  end

  // A software write to a counter overrides that cycle's increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_do_write && csr_addr == c_A_MCYCLE) r_mcycle <= w_wval[CNT_W-1:0];
      else                                      r_mcycle <= r_mcycle + CNT_W'(1);
      if (w_do_write && csr_addr == c_A_MINSTRET) r_minstret <= w_wval[CNT_W-1:0];
      else if (w_retire)                          r_minstret <= r_minstret + CNT_W'(1);
    end
  end

  assign csr_rdata      = w_rdata;
  assign csr_illegal    = w_illegal;
  assign irq_req        = w_irq_req;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign priv           = r_priv;
  assign satp           = r_satp;

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_unit
// Self-checking bench for csr_trap_unit: CSR table, trap sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid, csr_we, exc_valid, mret, irq_accept;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, exc_pc, exc_tval, irq_epc;
  logic [5:0]  exc_code;
  logic [11:0] irq_in;

  logic [63:0] csr_rdata, redirect_pc, satp;
  logic        csr_illegal, irq_req, redirect_valid;
  logic [1:0]  priv;
  logic [63:0] s_csr_rdata, s_redirect_pc, s_satp;
  logic        s_csr_illegal, s_irq_req, s_redirect_valid;
  logic [1:0]  s_priv;

  always #5 clk = ~clk;

  csr_trap_unit #(.XLEN(64), .NUM_IRQ(12), .CNT_W(64), .HARTID(64'd5)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .csr_we(csr_we), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval), .mret(mret),
    .irq_in(irq_in), .irq_req(irq_req), .irq_accept(irq_accept), .irq_epc(irq_epc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .priv(priv), .satp(satp));

  csr_trap_unit #(.XLEN(64), .NUM_IRQ(12), .CNT_W(8), .HARTID(64'd5)) dut8 (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .csr_we(csr_we), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(s_csr_rdata), .csr_illegal(s_csr_illegal),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval), .mret(mret),
    .irq_in(irq_in), .irq_req(s_irq_req), .irq_accept(irq_accept), .irq_epc(irq_epc),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .priv(s_priv), .satp(s_satp));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: architectural values, mstatus kept as a masked word.
  logic [1:0]  m_priv;
  logic [63:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_satp;
  logic [11:0] m_mie, m_mip;
  logic [63:0] m_mcycle, m_minstret, m_rpc;
  logic        m_rv;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic m_reset();
    m_priv = 2'd3; m_mstatus = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_satp = 0; m_mie = 0; m_mip = 0;
    m_mcycle = 0; m_minstret = 0; m_rpc = 0; m_rv = 1'b0;
  endtask

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hF14, 12'h180: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] m_rd(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return {52'h0, m_mie};
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return {52'h0, m_mip};
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      12'hF14: return 64'd5;
      12'h180: return m_satp;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] m_rd8(input logic [11:0] a);
    if (a == 12'hB00) return {56'h0, m_mcycle[7:0]};
    if (a == 12'hB02) return {56'h0, m_minstret[7:0]};
    return m_rd(a);
  endfunction

  function automatic bit m_illegal();
    return !m_impl(csr_addr) || (m_priv < csr_addr[9:8]) ||
           (csr_op != 2'b00 && csr_addr[11:10] == 2'b11);
  endfunction

  function automatic bit m_irq_req();
    return ((m_mip & m_mie) != 0) && (m_priv != 2'd3 || m_mstatus[3]) && !m_rv;
  endfunction

  function automatic int m_idx();
    logic [11:0] p;
    p = m_mip & m_mie;
    for (int i = 11; i >= 0; i--) if (p[i]) return i;
    return 0;
  endfunction

  task automatic m_update();
    bit ti, te, tm, tw;
    logic [63:0] old, wv, ncyc, ninst, base;
    int idx;
    ti = irq_accept && m_irq_req();
    te = !ti && commit_valid && exc_valid;
    tm = !ti && !te && commit_valid && mret;
    tw = !ti && !te && !tm && commit_valid && csr_we && csr_op != 2'b00 && !m_illegal();
    old = m_rd(csr_addr);
    case (csr_op)
      2'b01:   wv = csr_wdata;
      2'b10:   wv = old | csr_wdata;
      2'b11:   wv = old & ~csr_wdata;
      default: wv = old;
    endcase
    ncyc  = m_mcycle + 1;
    ninst = (commit_valid && !exc_valid && !ti) ? m_minstret + 1 : m_minstret;
    base  = m_mtvec & ~64'h3;
    m_rv  = 1'b0;
    if (ti || te) begin
      m_mstatus = ({62'h0, m_priv} << 11) | (m_mstatus[3] ? 64'h80 : 64'h0);
      m_priv = 2'd3;
      m_rv = 1'b1;
      if (ti) begin
        idx = m_idx();
        m_mepc = irq_epc & ~64'h3; m_mtval = 0;
        m_mcause = 64'h8000_0000_0000_0000 + 64'(idx);
        m_rpc = m_mtvec[0] ? base + 64'(4 * idx) : base;
      end else begin
        m_mepc = exc_pc & ~64'h3; m_mtval = exc_tval; m_mcause = {58'h0, exc_code};
        m_rpc = base;
      end
    end else if (tm) begin
      m_rpc = m_mepc;
      m_rv = 1'b1;
      m_priv = m_mstatus[12:11];
      m_mstatus = 64'h80 | (m_mstatus[7] ? 64'h8 : 64'h0);
    end else if (tw) begin
      case (csr_addr)
        12'h300: m_mstatus  = wv & 64'h1888;
        12'h304: m_mie      = wv[11:0];
        12'h305: m_mtvec    = wv & ~64'h2;
        12'h340: m_mscratch = wv;
        12'h341: m_mepc     = wv & ~64'h3;
        12'h342: m_mcause   = wv;
        12'h343: m_mtval    = wv;
        12'h180: m_satp     = wv;
        12'hB00: ncyc       = wv;
        12'hB02: ninst      = wv;
        default: ;
      endcase
    end
    m_mcycle = ncyc;
    m_minstret = ninst;
    m_mip = irq_in;
  endtask

  task automatic model_check();
    chk("rdata", csr_rdata, m_rd(csr_addr));
    chk("illegal", 64'(csr_illegal), 64'(m_illegal()));
    chk("irq_req", 64'(irq_req), 64'(m_irq_req()));
    chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
    if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    chk("priv", 64'(priv), 64'(m_priv));
    chk("satp", satp, m_satp);
    chk("rdata_cnt8", s_csr_rdata, m_rd8(csr_addr));
  endtask

  // Inputs are driven just after posedge; checks on negedge; model steps at the edge.
  task automatic cycle();
    @(negedge clk);
    model_check();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    commit_valid = 0; csr_we = 0; csr_op = 2'b00; csr_addr = 12'h300; csr_wdata = 0;
    exc_valid = 0; exc_code = 0; exc_pc = 0; exc_tval = 0; mret = 0;
    irq_accept = 0; irq_epc = 0;
  endtask

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
    idle(); commit_valid = 1; csr_we = 1; csr_op = op; csr_addr = a; csr_wdata = d;
    cycle();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic        ill;
    logic [63:0] rd;
  } vec_t;

  vec_t        tbl[13];
  logic [11:0] addrs[16];
  logic [63:0] v;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b01, 12'hF14, 64'h1,        1'b1, 64'h5};
    tbl[1]  = '{2'b10, 12'h300, 64'hFFFF,     1'b0, 64'h1888};
    tbl[2]  = '{2'b11, 12'h300, 64'h8,        1'b0, 64'h1880};
    tbl[3]  = '{2'b01, 12'h305, 64'h1003,     1'b0, 64'h1001};
    tbl[4]  = '{2'b01, 12'h304, 64'hFFFFFFFF, 1'b0, 64'hFFF};
    tbl[5]  = '{2'b01, 12'h341, 64'h123,      1'b0, 64'h120};
    tbl[6]  = '{2'b01, 12'h344, 64'hFF,       1'b0, 64'h0};
    tbl[7]  = '{2'b01, 12'h180, 64'hABCD,     1'b0, 64'hABCD};
    tbl[8]  = '{2'b01, 12'h7C0, 64'h1,        1'b1, 64'h0};
    tbl[9]  = '{2'b01, 12'h340, 64'hDEAD,     1'b0, 64'hDEAD};
    tbl[10] = '{2'b10, 12'h340, 64'hF0000,    1'b0, 64'hFDEAD};
    tbl[11] = '{2'b01, 12'h342, 64'h5,        1'b0, 64'h5};
    tbl[12] = '{2'b10, 12'h300, 64'h8,        1'b0, 64'h1888};
    addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
              12'hB00, 12'hB02, 12'hF14, 12'h180, 12'h7C0, 12'h301, 12'hB01, 12'h300};

    rst = 1; idle(); irq_in = 0;
    repeat (2) @(posedge clk);
    #1; rst = 0; m_reset();
    #1;
    chk("rst_priv", 64'(priv), 64'd3);
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    chk("rst_irq_req", 64'(irq_req), 64'd0);
    chk("rst_mstatus", csr_rdata, 64'd0);
    cycle();

    for (int i = 0; i < 13; i++) begin
      idle(); commit_valid = 1; csr_we = 1;
      csr_op = tbl[i].op; csr_addr = tbl[i].addr; csr_wdata = tbl[i].wdata;
      #1; chk($sformatf("tbl%0d_illegal", i), 64'(csr_illegal), 64'(tbl[i].ill));
      cycle();
      idle(); csr_addr = tbl[i].addr;
      #1; chk($sformatf("tbl%0d_read", i), csr_rdata, tbl[i].rd);
      cycle();
    end

    // Vectored interrupt 7
    idle(); irq_in = 12'h080;
    #1; chk("irq_lat0", 64'(irq_req), 64'd0);
    cycle();
    #1; chk("irq_lat1", 64'(irq_req), 64'd1);
    irq_accept = 1; irq_epc = 64'h80000010;
    cycle();
    idle(); csr_addr = 12'h342;
    #1; chk("irq_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("irq_redirect_pc", redirect_pc, 64'h101C);
    chk("irq_mcause", csr_rdata, 64'h8000_0000_0000_0007);
    chk("irq_priv", 64'(priv), 64'd3);
    chk("irq_req_drop", 64'(irq_req), 64'd0);
    cycle();
    csr_addr = 12'h341; irq_in = 0;
    #1; chk("irq_mepc", csr_rdata, 64'h80000010);
    cycle();
    csr_addr = 12'h300;
    #1; chk("irq_mstatus", csr_rdata, 64'h1880);
    cycle();

    // Drop to user mode, fault there, return
    csr_wr(2'b11, 12'h300, 64'h1800);
    csr_wr(2'b01, 12'h341, 64'h200);
    idle(); commit_valid = 1; mret = 1; cycle();
    idle(); #1;
    chk("mret_priv", 64'(priv), 64'd0);
    chk("mret_pc", redirect_pc, 64'h200);
    cycle();
    idle(); commit_valid = 1; exc_valid = 1; exc_code = 6'd8; exc_pc = 64'h40; exc_tval = 64'h99;
    cycle();
    idle(); csr_addr = 12'h300; #1;
    chk("exc_redirect_pc", redirect_pc, 64'h1000);
    chk("exc_priv", 64'(priv), 64'd3);
    chk("exc_mpp", 64'(csr_rdata[12:11]), 64'd0);
    cycle();
    csr_addr = 12'h342; #1; chk("exc_mcause", csr_rdata, 64'd8);
    commit_valid = 1; mret = 1; cycle();
    idle(); csr_addr = 12'h300; #1;
    chk("ret_priv", 64'(priv), 64'd0);
    chk("ret_pc", redirect_pc, 64'h40);
    chk("ret_mpie", 64'(csr_rdata[7]), 64'd1);
    chk("user_illegal", 64'(csr_illegal), 64'd1);
    cycle();

    // Exception and mret together: exception wins
    idle(); commit_valid = 1; exc_valid = 1; mret = 1; exc_code = 6'd2; exc_pc = 64'h80;
    cycle();
    idle(); csr_addr = 12'h342; #1;
    chk("both_mcause", csr_rdata, 64'd2);
    chk("both_pc", redirect_pc, 64'h1000);
    cycle();

    // mret re-enables MIE with interrupt 3 pending
    idle(); irq_in = 12'h008; cycle();
    #1; chk("pend_masked", 64'(irq_req), 64'd0);
    commit_valid = 1; mret = 1; cycle();
    idle(); #1;
    chk("pulse_no_irq", 64'(irq_req), 64'd0);
    chk("pulse_valid", 64'(redirect_valid), 64'd1);
    cycle();
    #1; chk("after_pulse_irq", 64'(irq_req), 64'd1);
    irq_accept = 1; irq_epc = 64'h300; cycle();
    idle(); irq_in = 0; #1;
    chk("irq3_pc", redirect_pc, 64'h100C);
    cycle();

    // mcycle write wins, then counts
    csr_wr(2'b01, 12'hB00, 64'h0);
    idle(); csr_addr = 12'hB00; #1; chk("mcycle_w0", csr_rdata, 64'd0);
    cycle();
    #1; chk("mcycle_w1", csr_rdata, 64'd1);
    cycle();

    // Faulting commit not counted
    idle(); csr_addr = 12'hB02; commit_valid = 1; exc_valid = 1; exc_code = 6'd5;
    #1; v = csr_rdata;
    cycle();
    idle(); csr_addr = 12'hB02; #1; chk("minstret_fault", csr_rdata, v);
    commit_valid = 1; cycle();
    idle(); csr_addr = 12'hB02; #1; chk("minstret_inc", csr_rdata, v + 1);
    cycle();

    // 8-bit counter wrap
    csr_wr(2'b01, 12'hB00, 64'hFF);
    idle(); csr_addr = 12'hB00; #1; chk("wrap_ff", s_csr_rdata, 64'hFF);
    cycle();
    #1; chk("wrap_00", s_csr_rdata, 64'h0);
    chk("nowrap_100", csr_rdata, 64'h100);
    cycle();

    for (int k = 0; k < 400; k++) begin
      idle();
      commit_valid = ($urandom_range(0, 3) != 0);
      exc_valid    = ($urandom_range(0, 7) == 0);
      mret         = ($urandom_range(0, 7) == 0);
      csr_we       = ($urandom_range(0, 1) == 1);
      csr_op       = 2'($urandom_range(0, 3));
      csr_addr     = addrs[$urandom_range(0, 15)];
      csr_wdata    = {$urandom(), $urandom()};
      exc_code     = 6'($urandom());
      exc_pc       = {$urandom(), $urandom()};
      exc_tval     = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) irq_in = 12'($urandom());
      irq_accept   = !commit_valid && ($urandom_range(0, 1) == 1);
      irq_epc      = {$urandom(), $urandom()};
      cycle();
    end

    // Reset during the redirect pulse
    idle(); irq_in = 0; commit_valid = 1; exc_valid = 1; exc_code = 6'd3; cycle();
    idle(); #1; chk("pre_rst_pulse", 64'(redirect_valid), 64'd1);
    rst = 1; #1; m_reset();
    chk("rst_mid_valid", 64'(redirect_valid), 64'd0);
    chk("rst_mid_pc", redirect_pc, 64'd0);
    chk("rst_mid_priv", 64'(priv), 64'd3);
    @(posedge clk); #1; rst = 0;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
